keypad_scan_debounce: RTL and testbench

Front end for the tic-tac-toe board inputs. It scans a 3x3 passive key matrix, debounces and qualifies a single key press, and produces the per-cell button strobes `a_button`..`i_button` that feed the game core. It is the producer side of the game core's button interface. It also exports an encoded key code for other consumers.

---
 rtl/keypad_scan_debounce_if.sv | 40 ++++
 rtl/keypad_scan_debounce.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_debounce_if.sv
// Keypad / button bundle between the scanner and its neighbours.
//   col_n       : column drive, active-low, one-hot-low (scanner -> matrix)
//   row_n       : row sense, active-low, already synchronised (matrix -> scanner)
//   a..i_button : per-cell press pulses, active-low, idle high (scanner -> game core)
//   key_code    : index of the last accepted key, 0=a .. 8=i
//   key_strobe  : one-cycle high when a key is accepted
//   fsm_state   : debug view of the qualifier FSM (IDLE=0, CONFIRM=1, FIRE=2, WAIT_RELEASE=3)
// Handshake: key_strobe is a one-cycle valid qualifier for key_code. There is
// no ready; consumers must take the code in the strobe cycle. key_code then
// holds until the next acceptance.
interface keypad_scan_debounce_if;
  logic [2:0] col_n;
  logic [2:0] row_n;
  logic       a_button;
  logic       b_button;
  logic       c_button;
  logic       d_button;
  logic       e_button;
  logic       f_button;
  logic       g_button;
  logic       h_button;
  logic       i_button;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [1:0] fsm_state;

  modport master (
    output col_n, a_button, b_button, c_button, d_button, e_button,
           f_button, g_button, h_button, i_button, key_code, key_strobe,
           fsm_state,
    input  row_n
  );

  modport slave (
    input  col_n, a_button, b_button, c_button, d_button, e_button,
           f_button, g_button, h_button, i_button, key_code, key_strobe,
           fsm_state,
    output row_n
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 3x3 key matrix scanner with frame-based debounce and press qualification.
// Drives one column low at a time for SCAN_DIV cycles, samples the rows at the
// end of each dwell, classifies each 3-column frame as NONE / ONE(k) / MULTI,
// and accepts a key after DEBOUNCE_FRAMES identical ONE(k) frames. An accepted
// key produces a PULSE_CYCLES-wide active-low pulse on its cell button plus a
// one-cycle key_strobe, then the key must be released for DEBOUNCE_FRAMES
// frames before another press is accepted.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   kp    : keypad bundle (master side), see keypad_scan_debounce_if
module keypad_scan_debounce #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int PULSE_CYCLES    = 16
) (
  input logic              clk,
  input logic              reset,
  keypad_scan_debounce_if.master kp
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_FRAMES);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, FIRE, WAIT_RELEASE} state_t;

  // Scan datapath
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       hit_cnt;   // saturates at 2: anything above 1 is MULTI
  logic [3:0]       last_hit;

  logic [1:0] row_hits;
  logic [1:0] row_idx;
  logic [3:0] cell_idx;
  logic [2:0] frame_sum;
  logic [3:0] frame_idx;
  logic       sample;
  logic       frame_end;
  logic       f_none;
  logic       f_one;

  // Qualifier state
  state_t             state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [DB_W-1:0]    cnt_q, cnt_d;
  logic [DB_W-1:0]    rel_q, rel_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [3:0]         code_q, code_d;

  // Decode the rows seen during the current column's dwell.
  always_comb begin
    row_hits = 2'd0;
    row_idx  = 2'd0;
    for (int r = 0; r < 3; r++) begin
      if (!kp.row_n[r]) begin
        row_hits = row_hits + 2'd1;
        row_idx  = 2'(r);
      end
    end
    cell_idx  = ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx};
    sample    = (div_cnt == DIV_LAST);
    frame_end = sample && (col_idx == 2'd2);
    // The last column's sample is folded in combinationally so the frame
    // result is available on the wrap cycle itself.
    frame_sum = {1'b0, hit_cnt} + {1'b0, row_hits};
    frame_idx = (row_hits != 2'd0) ? cell_idx : last_hit;
    f_none    = frame_end && (frame_sum == 3'd0);
    f_one     = frame_end && (frame_sum == 3'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      col_idx  <= 2'd0;
      hit_cnt  <= 2'd0;
      last_hit <= 4'd0;
    end else if (sample) begin
      div_cnt <= '0;
      if (col_idx == 2'd2) begin
        col_idx  <= 2'd0;
        hit_cnt  <= 2'd0;
        last_hit <= 4'd0;
      end else begin
        col_idx <= col_idx + 2'd1;
        hit_cnt <= (frame_sum > 3'd2) ? 2'd2 : frame_sum[1:0];
        if (row_hits != 2'd0) last_hit <= cell_idx;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      rel_q   <= '0;
      pulse_q <= '0;
      code_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    pulse_d = pulse_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (f_one) begin
          cand_d  = frame_idx;
          cnt_d   = DB_W'(1);
          state_d = (DEBOUNCE_FRAMES == 1) ? FIRE : CONFIRM;
        end
      end
      CONFIRM: begin
        if (f_one) begin
          if (frame_idx == cand_q) begin
            cnt_d = (cnt_q == DB_MAX) ? cnt_q : cnt_q + 1'b1;
            if (cnt_d == DB_MAX) state_d = FIRE;
          end else begin
            cand_d = frame_idx;
            cnt_d  = DB_W'(1);
          end
        end else if (frame_end) begin
          state_d = IDLE;
        end
      end
      FIRE: begin
        // Frame results are ignored here; only the pulse timer matters.
        if (pulse_q == PULSE_LAST) begin
          state_d = WAIT_RELEASE;
          pulse_d = '0;
          rel_d   = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (f_none) begin
          rel_d = (rel_q == DB_MAX) ? rel_q : rel_q + 1'b1;
          if (rel_d == DB_MAX) state_d = IDLE;
        end else if (frame_end) begin
          rel_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Latch the code on entry so it is valid in the first FIRE cycle.
    if (state_q != FIRE && state_d == FIRE) begin
      code_d  = cand_d;
      pulse_d = '0;
    end
  end

  logic [8:0] btn_n;
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      btn_n[k] = !((state_q == FIRE) && (cand_q == 4'(k)));
    end
  end

  assign kp.col_n      = ~(3'b001 << col_idx);
  assign kp.a_button   = btn_n[0];
  assign kp.b_button   = btn_n[1];
  assign kp.c_button   = btn_n[2];
  assign kp.d_button   = btn_n[3];
  assign kp.e_button   = btn_n[4];
  assign kp.f_button   = btn_n[5];
  assign kp.g_button   = btn_n[6];
  assign kp.h_button   = btn_n[7];
  assign kp.i_button   = btn_n[8];
  assign kp.key_code   = code_q;
  assign kp.key_strobe = (state_q == FIRE) && (pulse_q == '0);
  assign kp.fsm_state  = state_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_FRAMES=2,
// PULSE_CYCLES=3 (frame = 12 cycles). Key presses are applied at frame
// boundaries; each expected acceptance is queued as {cycle, code} and a
// monitor checks every strobe and button pulse against the queue.
module tb_keypad_scan_debounce;
  localparam int PC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_debounce_if kp();

  keypad_scan_debounce #(
    .SCAN_DIV(4),
    .DEBOUNCE_FRAMES(2),
    .PULSE_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  // Passive matrix model: a pressed key pulls its row low while its column is driven.
  logic [8:0] keys = 9'd0;
  always_comb begin
    kp.row_n = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
  end

  logic [8:0] btn_low;
  assign btn_low = ~{kp.i_button, kp.h_button, kp.g_button, kp.f_button,
                     kp.e_button, kp.d_button, kp.c_button, kp.b_button,
                     kp.a_button};

  // Posedges since the last reset release.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int passes = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_fire(input int c, input int code);
    exp_q.push_back({16'(c), 4'(code)});
  endtask

  // Monitor / scoreboard
  initial begin
    int low_len;
    logic [3:0] last_code;
    logic [19:0] e;
    logic [8:0] one_hot;
    low_len = 0;
    last_code = 4'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        low_len = 0;
      end else begin
        if (kp.key_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(kp.key_strobe), 0);
          end else begin
            e = exp_q.pop_front();
            one_hot = 9'd1;
            one_hot = one_hot << e[3:0];
            check("strobe_cycle", cyc, 32'(e[19:4]));
            check("key_code", 32'(kp.key_code), 32'(e[3:0]));
            check("strobe_button", 32'(btn_low), 32'(one_hot));
            check("strobe_first", low_len, 0);
            last_code = e[3:0];
          end
        end
        if (btn_low != 9'd0) begin
          if (low_len == 0) check("pulse_start_strobe", 32'(kp.key_strobe), 1);
          check("one_low", $countones(btn_low), 1);
          check("fire_state", 32'(kp.fsm_state), 2);
          low_len++;
        end else if (low_len != 0) begin
          check("pulse_width", low_len, PC);
          check("key_code_hold", 32'(kp.key_code), 32'(last_code));
          low_len = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    // 1: reset state and column stepping
    check("rst_col_n", 32'(kp.col_n), 32'h6);
    check("rst_buttons", 32'(btn_low), 0);
    check("rst_key_code", 32'(kp.key_code), 0);
    check("rst_strobe", 32'(kp.key_strobe), 0);
    check("rst_state", 32'(kp.fsm_state), 0);
    goto(1);  check("col0", 32'(kp.col_n), 32'h6);
    goto(5);  check("col1", 32'(kp.col_n), 32'h5);
    goto(9);  check("col2", 32'(kp.col_n), 32'h3);
    goto(13); check("col_wrap", 32'(kp.col_n), 32'h6);

    // 2: hold e, accepted at the 2nd frame end, no re-fire for 10 frames
    goto(24);  keys = 9'b000010000; expect_fire(48, 4);
    // 5: unqualified release, then qualified release and re-press
    goto(168); keys = 9'd0;
    goto(180); keys = 9'b000010000;
    goto(216); keys = 9'd0;
    goto(240); keys = 9'b000010000; expect_fire(264, 4);
    goto(288); keys = 9'd0;
    // 3: one-frame bounce
    goto(312); keys = 9'b000010000;
    goto(324); keys = 9'd0;
    // 4: a and i together -> MULTI
    goto(348); keys = 9'b100000001;
    goto(396); keys = 9'd0;
    // g (row2/col0)
    goto(408); keys = 9'b001000000; expect_fire(432, 6);
    goto(432); keys = 9'd0;
    // c for one frame, then b: candidate switches, b accepted
    goto(456); keys = 9'b000000100;
    goto(468); keys = 9'b000000010; expect_fire(492, 1);
    goto(492); keys = 9'd0;
    // 6: reset in the 2nd pulse cycle of e
    goto(516); keys = 9'b000010000; expect_fire(540, 4);
    goto(541);
    #2 reset = 1'b1;
    #1;
    check("midpulse_e_button", 32'(kp.e_button), 1);
    check("midpulse_key_code", 32'(kp.key_code), 0);
    check("midpulse_strobe", 32'(kp.key_strobe), 0);
    check("midpulse_col_n", 32'(kp.col_n), 32'h6);
    @(negedge clk);
    #2 reset = 1'b0;
    expect_fire(24, 4);
    goto(48); keys = 9'd0;
    goto(80);
    check("pending_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
